// File: rtl/dmem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_loader_if
// Description : Loader byte stream and CPU memory-port bundle for dmem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_loader_if;
    // Loader byte stream (valid/ready)
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;

    // CPU memory port
    logic [7:0] cpu_addr;
    logic       cpu_r_n;
    logic       cpu_w_n;
    logic [7:0] cpu_wdata;
    logic       cpu_stop;
    logic [7:0] cpu_rdata;
    logic       cpu_rst;

    modport master (
        output ld_valid, ld_data, ld_last,
        output cpu_addr, cpu_r_n, cpu_w_n, cpu_wdata, cpu_stop,
        input  ld_ready, cpu_rdata, cpu_rst
    );

    modport slave (
        input  ld_valid, ld_data, ld_last,
        input  cpu_addr, cpu_r_n, cpu_w_n, cpu_wdata, cpu_stop,
        output ld_ready, cpu_rdata, cpu_rst
    );
endinterface
`default_nettype wire

// File: rtl/dmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : dmem_loader
// Description : 256x8 program/data RAM with stream boot loader, CPU reset
//               sequencing, memory-mapped output port and run-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_loader #(
    parameter logic [7:0] IO_ADDR = 8'hFF,
    parameter int         CYC_W   = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    dmem_loader_if.slave          bus,
    input  wire logic             reload,
    output logic                  io_valid,
    output logic [7:0]            io_data,
    output logic [8:0]            load_len,
    output logic [CYC_W-1:0]      run_cycles,
    output logic                  halted
);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [7:0]         r_mem [0:255];
    logic [7:0]         r_ptr;
    logic [8:0]         r_load_len;
    logic [CYC_W-1:0]   r_run_cycles;
    logic               r_io_valid;
    logic [7:0]         r_io_data;

    logic               w_ld_fire;
    logic               w_cpu_wr;
    logic               w_io_hit;
    logic               w_mem_we;
    logic [7:0]         w_mem_addr;
    logic [7:0]         w_mem_wdata;

    // reload takes priority: a byte or CPU write coinciding with it is dropped
    assign w_ld_fire   = (r_state == S_LOAD) && bus.ld_valid && !reload;
    assign w_cpu_wr    = (r_state == S_RUN) && !bus.cpu_w_n && !reload;
    assign w_io_hit    = (bus.cpu_addr == IO_ADDR);
    assign w_mem_we    = w_ld_fire || (w_cpu_wr && !w_io_hit);
    assign w_mem_addr  = w_ld_fire ? r_ptr : bus.cpu_addr;
    assign w_mem_wdata = w_ld_fire ? bus.ld_data : bus.cpu_wdata;

    // RAM has no reset; contents are undefined until loaded
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.ld_ready  = 1'b0;
        bus.cpu_rst   = 1'b0;
        bus.cpu_rdata = 8'h00;
        halted        = 1'b0;

        case (r_state)
            S_LOAD: begin
                bus.ld_ready = 1'b1;
                bus.cpu_rst  = 1'b1;
                if (w_ld_fire && (bus.ld_last || (r_ptr == 8'hFF))) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                bus.cpu_rst = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // Same-cycle read: the CPU samples mem_in on the edge R is low
                if (!bus.cpu_r_n && !w_io_hit) begin
                    bus.cpu_rdata = r_mem[bus.cpu_addr];
                end
                if (bus.cpu_stop) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase

        if (reload) begin
            w_state_nxt = S_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= 8'h00;
            r_load_len   <= 9'd0;
            r_run_cycles <= '0;
            r_io_valid   <= 1'b0;
            r_io_data    <= 8'h00;
        end else begin
            r_io_valid <= w_cpu_wr && w_io_hit;
            if (w_cpu_wr && w_io_hit) begin
                r_io_data <= bus.cpu_wdata;
            end

            if (reload) begin
                r_ptr        <= 8'h00;
                r_load_len   <= 9'd0;
                r_run_cycles <= '0;
            end else begin
                if (w_ld_fire) begin
                    r_ptr      <= r_ptr + 8'd1;
                    r_load_len <= r_load_len + 9'd1;
                end
                if ((r_state == S_RUN) && (r_run_cycles != {CYC_W{1'b1}})) begin
                    r_run_cycles <= r_run_cycles + 1'b1;
                end
            end
        end
    end

    assign io_valid   = r_io_valid;
    assign io_data    = r_io_data;
    assign load_len   = r_load_len;
    assign run_cycles = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_dmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_loader
// Description : Scoreboard bench for dmem_loader (narrow run counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_loader;

    localparam int         C_CYC_W = 4;
    localparam logic [7:0] C_IO    = 8'hFF;

    logic               clk = 1'b0;
    logic               rst;
    logic               reload;
    logic               io_valid;
    logic [7:0]         io_data;
    logic [8:0]         load_len;
    logic [C_CYC_W-1:0] run_cycles;
    logic               halted;

    int n_vec     = 0;
    int n_err     = 0;
    int io_pulses = 0;

    logic [7:0] rd_q[$];
    logic [7:0] io_q[$];

    dmem_loader_if bus ();

    dmem_loader #(
        .IO_ADDR (C_IO),
        .CYC_W   (C_CYC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .reload     (reload),
        .io_valid   (io_valid),
        .io_data    (io_data),
        .load_len   (load_len),
        .run_cycles (run_cycles),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output-port monitor: every io_valid pulse must match a queued write
    always @(negedge clk) begin
        if (io_valid === 1'b1) begin
            io_pulses++;
            if (io_q.size() == 0) begin
                chk("io_unexpected", 32'd1, 32'd0);
            end else begin
                chk("io_data", {24'd0, io_data}, {24'd0, io_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic last);
        int k;
        k = 0;
        while (bus.ld_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (k == 20) chk("ld_ready_timeout", 32'd0, 32'd1);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        bus.cpu_addr = a;
        bus.cpu_r_n  = 1'b0;
        rd_q.push_back(exp);
        @(negedge clk);
        chk($sformatf("rd_%02h", a), {24'd0, bus.cpu_rdata}, {24'd0, rd_q.pop_front()});
        tick();
        bus.cpu_r_n = 1'b1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic exp_io);
        if (exp_io) io_q.push_back(d);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_w_n   = 1'b0;
        tick();
        bus.cpu_w_n   = 1'b1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_ld_ready"},   {31'd0, bus.ld_ready}, 32'd1);
        chk({pfx, "_cpu_rst"},    {31'd0, bus.cpu_rst},  32'd1);
        chk({pfx, "_io_valid"},   {31'd0, io_valid},     32'd0);
        chk({pfx, "_io_data"},    {24'd0, io_data},      32'd0);
        chk({pfx, "_load_len"},   {23'd0, load_len},     32'd0);
        chk({pfx, "_run_cycles"}, {28'd0, run_cycles},   32'd0);
        chk({pfx, "_halted"},     {31'd0, halted},       32'd0);
        chk({pfx, "_cpu_rdata"},  {24'd0, bus.cpu_rdata}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [C_CYC_W-1:0] rc;

        rst = 1'b1; reload = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_data = 8'h00; bus.ld_last = 1'b0;
        bus.cpu_addr = 8'h00; bus.cpu_r_n = 1'b1; bus.cpu_w_n = 1'b1;
        bus.cpu_wdata = 8'h00; bus.cpu_stop = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        tick();
        rst = 1'b0;

        // Short image: c0 05 c2 ff cc
        send_byte(8'hC0, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'hC2, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hCC, 1'b1);
        chk("rel_load_len", {23'd0, load_len}, 32'd5);
        chk("rel_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("rel_cpu_rst",  {31'd0, bus.cpu_rst}, 32'd1);
        tick();
        chk("run_cpu_rst",  {31'd0, bus.cpu_rst}, 32'd0);
        chk("run_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("run_cyc0",     {28'd0, run_cycles}, 32'd0);

        rd(8'h00, 8'hC0);
        rd(8'h01, 8'h05);
        rd(8'h04, 8'hCC);
        rd(C_IO,  8'h00);
        wr(C_IO, 8'h05, 1'b1);
        chk("io_pulse_hi", {31'd0, io_valid}, 32'd1);
        tick();
        chk("io_pulse_lo", {31'd0, io_valid}, 32'd0);
        rd(8'h03, 8'hFF);

        bus.cpu_stop = 1'b1;
        tick();
        bus.cpu_stop = 1'b0;
        chk("halted", {31'd0, halted}, 32'd1);
        chk("halt_cpu_rst", {31'd0, bus.cpu_rst}, 32'd0);
        rc = run_cycles;
        chk("rc_nonzero", {31'd0, (rc != '0)}, 32'd1);
        wr(8'h01, 8'h77, 1'b0);
        wr(C_IO, 8'h33, 1'b0);
        repeat (3) tick();
        chk("rc_frozen", {28'd0, run_cycles}, {28'd0, rc});
        rd(8'h01, 8'h00);
        chk("halt_io_data", {24'd0, io_data}, 32'd5);

        // Reload from HALT; one-byte image keeps RAM[1] from before
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("rl_load_len", {23'd0, load_len}, 32'd0);
        chk("rl_halted",   {31'd0, halted}, 32'd0);
        chk("rl_run",      {28'd0, run_cycles}, 32'd0);
        chk("rl_cpu_rst",  {31'd0, bus.cpu_rst}, 32'd1);
        chk("rl_io_data",  {24'd0, io_data}, 32'd5);
        send_byte(8'h5A, 1'b1);
        chk("one_load_len", {23'd0, load_len}, 32'd1);
        tick();
        rd(8'h00, 8'h5A);
        rd(8'h01, 8'h05);

        // Reload from RUN, then full 256-byte image without ld_last
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("rl2_cpu_rst", {31'd0, bus.cpu_rst}, 32'd1);
        for (int i = 0; i < 256; i++) send_byte(i[7:0], 1'b0);
        chk("full_load_len", {23'd0, load_len}, 32'd256);
        chk("full_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("full_cpu_rst",  {31'd0, bus.cpu_rst}, 32'd1);
        tick();
        for (int i = 0; i < 256; i++) rd(i[7:0], (i == 255) ? 8'h00 : i[7:0]);

        // Simultaneous read and write: old data now, new data next cycle
        bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'hAA;
        bus.cpu_r_n = 1'b0; bus.cpu_w_n = 1'b0;
        rd_q.push_back(8'h10);
        @(negedge clk);
        chk("rw_old", {24'd0, bus.cpu_rdata}, {24'd0, rd_q.pop_front()});
        tick();
        bus.cpu_w_n = 1'b1;
        rd_q.push_back(8'hAA);
        @(negedge clk);
        chk("rw_new", {24'd0, bus.cpu_rdata}, {24'd0, rd_q.pop_front()});
        tick();
        bus.cpu_r_n = 1'b1;

        repeat (20) tick();
        chk("run_sat", {28'd0, run_cycles}, 32'hF);

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        tick();
        rst = 1'b0;

        // Reload mid-load with a coincident byte that must be dropped
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        chk("mid_load_len3", {23'd0, load_len}, 32'd3);
        reload = 1'b1;
        bus.ld_valid = 1'b1; bus.ld_data = 8'h99;
        tick();
        reload = 1'b0;
        bus.ld_valid = 1'b0;
        chk("mid_load_len0", {23'd0, load_len}, 32'd0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b1);
        chk("mid_load_len2", {23'd0, load_len}, 32'd2);
        tick();
        rd(8'h00, 8'h44);
        rd(8'h01, 8'h55);
        rd(8'h02, 8'h33);
        rd(8'h03, 8'h03);

        chk("io_pulses", io_pulses, 32'd1);
        chk("io_q_empty", io_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
